// File: rtl/dram_arb_pkg.sv
// Shared types for the data-RAM arbiter.
// State encodings and port index constants.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_P0   = 2'd1,
    ARB_P1   = 2'd2
  } arb_state_t;

  localparam logic ARB_PORT_CPU = 1'b0;
  localparam logic ARB_PORT_DMA = 1'b1;

endpackage

// File: rtl/dram_arb_rdret.sv
// Read-return register: remembers which port issued a read
// and steers mem_rdata to it in the following cycle.
// Ports: clk, rst_n, rd_go/rd_sel (read accepted, by which port),
//        mem_rdata in; pN_rvalid/pN_rdata out.
module dram_arb_rdret
  import dram_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_go,
  input  logic        rd_sel,
  input  logic [31:0] mem_rdata,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata
);

  logic rd_pend;
  logic rd_port;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      rd_port <= ARB_PORT_CPU;
    end else begin
      rd_pend <= rd_go;
      if (rd_go) rd_port <= rd_sel;
    end
  end

  assign p0_rvalid = rd_pend & (rd_port == ARB_PORT_CPU);
  assign p1_rvalid = rd_pend & (rd_port == ARB_PORT_DMA);
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: rtl/dram_arb.sv
// Two-port round-robin arbiter for the data RAM, with
// bounded locked bursts. Port 0 = CPU, port 1 = DMA.
// Ports: pN_req/we/lock/addr/wdata in, pN_gnt/rvalid/rdata out,
//        mem_addr/we/wdata out, mem_rdata in.
// Option: DRAM_ARB_CPU_PRIO_EN makes port 0 win every idle tie.
module dram_arb
  import dram_arb_pkg::*;
#(
  parameter int AW        = 12,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic          p0_lock,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [31:0]   p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic          p1_lock,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [31:0]   p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST - 1);

  arb_state_t    state, state_n;
  logic          last, last_n;
  logic [BW-1:0] burst_cnt, burst_n;
  logic          tie;
  logic          pick0, pick1;
  logic          keep;

`ifdef DRAM_ARB_CPU_PRIO_EN
  assign tie = ARB_PORT_CPU;
`else
  assign tie = ~last;
`endif

  // Idle-style arbitration, also used when a lock owner drops req.
  assign pick0 = p0_req & (~p1_req | (tie == ARB_PORT_CPU));
  assign pick1 = p1_req & (~p0_req | (tie == ARB_PORT_DMA));
  assign keep  = burst_cnt < BMAX;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      last      <= 1'b1;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      burst_cnt <= burst_n;
    end
  end

  always_comb begin
    state_n = ARB_IDLE;
    last_n  = last;
    burst_n = '0;
    if (p0_gnt) begin
      state_n = p0_lock ? ARB_P0 : ARB_IDLE;
      last_n  = ARB_PORT_CPU;
      if (state == ARB_P0)
        burst_n = (burst_cnt == BMAX) ? burst_cnt : burst_cnt + 1'b1;
    end else if (p1_gnt) begin
      state_n = p1_lock ? ARB_P1 : ARB_IDLE;
      last_n  = ARB_PORT_DMA;
      if (state == ARB_P1)
        burst_n = (burst_cnt == BMAX) ? burst_cnt : burst_cnt + 1'b1;
    end
  end

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    unique case (state)
      ARB_P0: begin
        if (p0_req) begin
          p0_gnt = keep | ~p1_req;
          p1_gnt = ~keep & p1_req;
        end else begin
          p0_gnt = pick0;
          p1_gnt = pick1;
        end
      end
      ARB_P1: begin
        if (p1_req) begin
          p1_gnt = keep | ~p0_req;
          p0_gnt = ~keep & p0_req;
        end else begin
          p0_gnt = pick0;
          p1_gnt = pick1;
        end
      end
      default: begin
        p0_gnt = pick0;
        p1_gnt = pick1;
      end
    endcase
  end

  assign mem_addr  = p0_gnt ? p0_addr  : p1_gnt ? p1_addr  : '0;
  assign mem_wdata = p0_gnt ? p0_wdata : p1_gnt ? p1_wdata : '0;
  assign mem_we    = (p0_gnt & p0_we) | (p1_gnt & p1_we);

  dram_arb_rdret u_rdret (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_go     ((p0_gnt & ~p0_we) | (p1_gnt & ~p1_we)),
    .rd_sel    (p1_gnt ? ARB_PORT_DMA : ARB_PORT_CPU),
    .mem_rdata (mem_rdata),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata)
  );

endmodule

// File: tb/tb_dram_arb.sv
// Bench for dram_arb: directed scenarios plus random traffic,
// checked against a cycle-level model of the arbitration rules.
module tb_dram_arb;

  localparam int AW = 12;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_req = 0, p0_we = 0, p0_lock = 0;
  logic [AW-1:0] p0_addr = '0;
  logic [31:0]   p0_wdata = '0;
  logic          p1_req = 0, p1_we = 0, p1_lock = 0;
  logic [AW-1:0] p1_addr = '0;
  logic [31:0]   p1_wdata = '0;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0]   p0_rdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  logic [31:0] ram [0:(1<<AW)-1];
  logic [31:0] shadow [0:(1<<AW)-1];

  int nchk = 0;
  int nbad = 0;

  // model state: owner -1 = none
  int          m_own = -1;
  int          m_cnt = 0;
  int          m_last = 1;
  bit          m_pend = 0;
  int          m_pport = 0;
  logic [31:0] m_pdata = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  dram_arb #(.AW(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int mdl_grant(input bit r0, input bit r1);
    bit rq [2];
    int o;
    rq[0] = r0;
    rq[1] = r1;
    if (m_own >= 0 && rq[m_own]) begin
      o = 1 - m_own;
      if (m_cnt < MB - 1 || !rq[o]) return m_own;
      return o;
    end
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (!r0 && !r1) return -1;
`ifdef DRAM_ARB_CPU_PRIO_EN
    return 0;
`else
    return 1 - m_last;
`endif
  endfunction

  // One cycle: inputs were set at posedge+1 by the caller.
  task automatic step(output int g);
    bit          rq [2], we [2], lk [2];
    logic [11:0] ad [2];
    logic [31:0] wd [2];
    logic [1:0]  eg, ev;
    @(negedge clk);
    #1;
    rq[0] = p0_req; we[0] = p0_we; lk[0] = p0_lock;
    ad[0] = p0_addr; wd[0] = p0_wdata;
    rq[1] = p1_req; we[1] = p1_we; lk[1] = p1_lock;
    ad[1] = p1_addr; wd[1] = p1_wdata;
    g = mdl_grant(rq[0], rq[1]);
    eg = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
    ev = !m_pend ? 2'b00 : (m_pport == 0) ? 2'b01 : 2'b10;
    check("gnt", {62'd0, p1_gnt, p0_gnt}, {62'd0, eg});
    check("maddr", {52'd0, mem_addr},
          (g < 0) ? 64'd0 : {52'd0, ad[g]});
    check("mwe", {63'd0, mem_we},
          (g < 0) ? 64'd0 : {63'd0, we[g]});
    check("mwdata", {32'd0, mem_wdata},
          (g < 0) ? 64'd0 : {32'd0, wd[g]});
    check("rvalid", {62'd0, p1_rvalid, p0_rvalid}, {62'd0, ev});
    check("rdata0", {32'd0, p0_rdata},
          ev[0] ? {32'd0, m_pdata} : 64'd0);
    check("rdata1", {32'd0, p1_rdata},
          ev[1] ? {32'd0, m_pdata} : 64'd0);
    @(posedge clk);
    m_pend = 0;
    if (g >= 0) begin
      if (we[g]) shadow[ad[g]] = wd[g];
      else begin
        m_pend = 1;
        m_pport = g;
        m_pdata = shadow[ad[g]];
      end
      if (m_own == g) m_cnt = (m_cnt < MB - 1) ? m_cnt + 1 : m_cnt;
      else m_cnt = 0;
      m_own = lk[g] ? g : -1;
      m_last = g;
    end else begin
      m_own = -1;
      m_cnt = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    p0_req = 0;
    p1_req = 0;
    rst_n = 0;
    #1;
    check("rst_gnt", {62'd0, p1_gnt, p0_gnt}, 64'd0);
    check("rst_rv", {62'd0, p1_rvalid, p0_rvalid}, 64'd0);
    check("rst_rd", {p1_rdata, p0_rdata}, 64'd0);
    check("rst_mem", {19'd0, mem_we, mem_addr, mem_wdata}, 64'd0);
    m_own = -1; m_cnt = 0; m_last = 1; m_pend = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_hold(input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      step(g);
      if (g == 0) p0_req = 0;
      if (g == 1) p1_req = 0;
    end
  endtask

  initial begin
    int  g, k;
    bit  act [2];
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = 32'(i * 7 + 3);
      shadow[i] = 32'(i * 7 + 3);
    end
    #2;
    do_reset();
    run_hold(1);

    // simultaneous reads: p0 first, then p1
    p0_req = 1; p0_we = 0; p0_addr = 12'h004;
    p1_req = 1; p1_we = 0; p1_addr = 12'h008;
    run_hold(3);

    // unlocked contention alternates
    for (int i = 0; i < 6; i++) begin
      p0_req = 1; p1_req = 1;
      step(g);
    end
    p0_req = 0; p1_req = 0;
    run_hold(1);

    // p1 locked burst of writes against a steady p0 reader
    k = 0;
    p0_addr = 12'h020; p0_we = 0;
    for (int i = 0; i < 24 && k < 8; i++) begin
      p0_req = 1;
      p1_req = 1; p1_we = 1; p1_lock = 1;
      p1_addr = 12'(k); p1_wdata = 32'hA0 + 32'(k);
      step(g);
      if (g == 1) k++;
    end
    check("burst_done", 64'(k), 64'd8);
    p0_req = 0; p1_lock = 0; p1_we = 0;
    for (int i = 0; i < 8; i++) begin
      p1_req = 1; p1_addr = 12'(i);
      step(g);
    end
    p1_req = 0;
    run_hold(1);

    // write then read back
    p0_req = 1; p0_we = 1; p0_addr = 12'h010;
    p0_wdata = 32'hDEADBEEF;
    step(g);
    p0_we = 0;
    step(g);
    p0_req = 0;
    check("beef_v", {63'd0, p0_rvalid}, 64'd1);
    check("beef_d", {32'd0, p0_rdata}, 64'hDEADBEEF);
    run_hold(1);

    // reset with p1 lock owned and its read pending
    p1_req = 1; p1_lock = 1; p1_we = 0; p1_addr = 12'h003;
    step(g);
    do_reset();
    p1_lock = 0;
    p0_req = 1; p0_we = 0; p1_req = 1;
    step(g);
    check("tie_p0", 64'(g), 64'd0);
    p0_req = 0; p1_req = 0;
    run_hold(1);

    // contention then p0 backs off
    for (int i = 0; i < 4; i++) begin
      p0_req = 1; p1_req = 1;
      step(g);
    end
    p0_req = 0; p1_req = 1;
    step(g);
    p1_req = 0;
    run_hold(1);

    // random traffic, each request held until granted
    act[0] = 0; act[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!act[0] && $urandom_range(2) != 0) begin
        act[0] = 1;
        p0_we = 1'($urandom); p0_lock = 1'($urandom);
        p0_addr = 12'($urandom_range(15)); p0_wdata = $urandom;
      end
      if (!act[1] && $urandom_range(2) != 0) begin
        act[1] = 1;
        p1_we = 1'($urandom); p1_lock = 1'($urandom);
        p1_addr = 12'($urandom_range(15)); p1_wdata = $urandom;
      end
      p0_req = act[0];
      p1_req = act[1];
      step(g);
      if (g >= 0) act[g] = 0;
      if (i == 1500) begin
        do_reset();
        act[0] = 0; act[1] = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
